// File: rtl/whack_pkg.sv
// Shared definitions for the multi-mole whack-a-mole core.
// Holds the game state encoding and the LFSR width and feedback mask.
package whack_pkg;

   localparam int unsigned      LFSR_W    = 16;
   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_UP   = 2'd2;
   localparam logic [1:0] ST_END  = 2'd3;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StArm  = ST_ARM,
      StUp   = ST_UP,
      StEnd  = ST_END
   } state_e;

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick moles and appearance delays.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, loads seed
//   seed  - reset value, must be nonzero
//   q     - current LFSR state
module mole_lfsr16
   import whack_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] q_q;
   logic [LFSR_W-1:0] q_d;

   always_comb begin
      q_d = q_q >> 1;
      if (q_q[0]) begin
         q_d = q_d ^ LFSR_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/whack_a_mole_multi.sv
// Multi-mole whack-a-mole game core.
// Picks a random mole and appearance delay from an internal LFSR, scores hits on
// rising button edges, tracks lives and blinks all moles on the end screen.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   button - debounced level buttons, one per mole
//   mole   - mole LEDs, 1 = shown
//   score  - current or last score, saturating
//   lives  - remaining lives
//   state  - 0=IDLE 1=ARM 2=UP 3=END
//   hit    - one-cycle pulse on a scored hit
//   miss   - one-cycle pulse on a lost life
module whack_a_mole_multi
   import whack_pkg::*;
#(
   parameter int unsigned       N_MOLES         = 4,
   parameter int unsigned       SCORE_W         = 8,
   parameter int unsigned       LIVES_W         = 4,
   parameter int unsigned       START_LIVES     = 3,
   parameter int unsigned       MIN_DELAY_CYC   = 100_000_000,
   parameter int unsigned       DELAY_SPAN_LOG2 = 8,
   parameter int unsigned       DELAY_SHIFT     = 20,
   parameter int unsigned       HIT_WINDOW_CYC  = 100_000_000,
   parameter int unsigned       BLINK_CYC       = 50_000_000,
   parameter logic [LFSR_W-1:0] LFSR_SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_MOLES-1:0] button,
   output logic [N_MOLES-1:0] mole,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [1:0]         state,
   output logic               hit,
   output logic               miss
);

   localparam int unsigned SelW = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

   // One counter serves the arm delay, the hit window and the blink period,
   // so it is sized for the largest of the three.
   localparam longint unsigned DelayMax = 64'(MIN_DELAY_CYC) +
                                          (((64'd1 << DELAY_SPAN_LOG2) - 64'd1) << DELAY_SHIFT);
   localparam longint unsigned WinMax   = 64'(HIT_WINDOW_CYC);
   localparam longint unsigned BlinkMax = 64'(BLINK_CYC);
   localparam longint unsigned CntMax   = (DelayMax > WinMax) ?
                                          ((DelayMax > BlinkMax) ? DelayMax : BlinkMax) :
                                          ((WinMax > BlinkMax) ? WinMax : BlinkMax);
   localparam int unsigned     CntW     = $clog2(CntMax + 64'd1);

   logic [LFSR_W-1:0]  lfsr;
   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [SelW-1:0]    sel_q, sel_d, sel_new;
   logic [N_MOLES-1:0] sel_oh;
   logic [N_MOLES-1:0] mole_q, mole_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic [N_MOLES-1:0] button_prev_q, button_prev_d;
   logic [N_MOLES-1:0] btn_edge;
   logic [CntW-1:0]    delay_w;
   logic               arm;
   logic               lose;
   logic               unused_lfsr;

   mole_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr)
   );

   if (N_MOLES > 1) begin : g_sel
      assign sel_new = lfsr[LFSR_W-1 -: SelW];
   end else begin : g_sel_single
      assign sel_new = '0;
   end

   // Only a subset of the LFSR bits feeds sel and the delay.
   assign unused_lfsr = ^lfsr;

   assign btn_edge = button & ~button_prev_q;
   assign delay_w  = CntW'(MIN_DELAY_CYC) + (CntW'(lfsr[DELAY_SPAN_LOG2-1:0]) << DELAY_SHIFT);

   always_comb begin
      sel_oh         = '0;
      sel_oh[sel_q]  = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      sel_d         = sel_q;
      mole_d        = mole_q;
      score_d       = score_q;
      lives_d       = lives_q;
      hit_d         = 1'b0;
      miss_d        = 1'b0;
      button_prev_d = button;
      arm           = 1'b0;
      lose          = 1'b0;

      unique case (state_q)
         StIdle: begin
            mole_d = '0;
            if (|btn_edge) begin
               score_d = '0;
               lives_d = LIVES_W'(START_LIVES);
               arm     = 1'b1;
            end
         end
         StArm: begin
            if (cnt_q == '0) begin
               state_d = StUp;
               mole_d  = sel_oh;
               cnt_d   = CntW'(HIT_WINDOW_CYC - 1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StUp: begin
            // A stray edge elsewhere beats a simultaneous correct press.
            if (|(btn_edge & ~sel_oh)) begin
               lose = 1'b1;
            end else if (|(btn_edge & sel_oh)) begin
               hit_d = 1'b1;
               if (score_q != '1) begin
                  score_d = score_q + SCORE_W'(1);
               end
               arm = 1'b1;
            end else if (cnt_q == '0) begin
               lose = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StEnd: begin
            if (|btn_edge) begin
               state_d = StIdle;
               mole_d  = '0;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(BLINK_CYC - 1)) begin
               mole_d = ~mole_q;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      endcase

      if (lose) begin
         miss_d = 1'b1;
         mole_d = '0;
         if (lives_q == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = StEnd;
            mole_d  = '1;  // end screen starts lit
            cnt_d   = '0;
         end else begin
            lives_d = lives_q - LIVES_W'(1);
            arm     = 1'b1;
         end
      end

      if (arm) begin
         state_d = StArm;
         sel_d   = sel_new;
         cnt_d   = delay_w;
         mole_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         sel_q         <= '0;
         mole_q        <= '0;
         score_q       <= '0;
         lives_q       <= '0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         button_prev_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         mole_q        <= mole_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
         button_prev_q <= button_prev_d;
      end
   end

   assign mole  = mole_q;
   assign score = score_q;
   assign lives = lives_q;
   assign state = state_q;
   assign hit   = hit_q;
   assign miss  = miss_q;

endmodule

// File: tb/tb_whack_a_mole_multi.sv
// Scoreboard bench for whack_a_mole_multi. The game model works in absolute
// cycle timestamps: arming at time t predicts the mole and its appearance time
// from the LFSR value t cycles after reset; hits, misses and blinks are
// predicted as timestamped events and checked by an independent monitor.
module tb_whack_a_mole_multi;

   localparam int NM    = 4;
   localparam int MIND  = 8;
   localparam int WIN   = 16;
   localparam int BLINK = 4;
   localparam int LIV0  = 3;

   localparam int KAppear = 0;
   localparam int KHit    = 1;
   localparam int KMiss   = 2;
   localparam int KBlink  = 3;

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic [NM-1:0] button = '0;
   logic [NM-1:0] mole;
   logic [7:0]    score;
   logic [3:0]    lives;
   logic [1:0]    state;
   logic          hit;
   logic          miss;

   whack_a_mole_multi #(
      .N_MOLES         (NM),
      .SCORE_W         (8),
      .LIVES_W         (4),
      .START_LIVES     (LIV0),
      .MIN_DELAY_CYC   (MIND),
      .DELAY_SPAN_LOG2 (3),
      .DELAY_SHIFT     (0),
      .HIT_WINDOW_CYC  (WIN),
      .BLINK_CYC       (BLINK),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .button (button),
      .mole   (mole),
      .score  (score),
      .lives  (lives),
      .state  (state),
      .hit    (hit),
      .miss   (miss)
   );

   always #5 clk = ~clk;

   int tcnt = 0;
   always @(posedge clk) tcnt <= tcnt + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;
      int t;
      int mole;
      int score;
      int lives;
      int state;
   } exp_t;

   exp_t sb[$];

   int t_rst;
   int m_score;
   int m_lives;
   int m_sel;
   int m_appear;
   int m_end;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, tcnt);
      end
   endtask

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] x;
      x = 16'hACE1;
      for (int i = 0; i < n; i++) begin
         x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
      end
      return x;
   endfunction

   task automatic push(input int kind, input int t, input int mo, input int st);
      exp_t e;
      e.kind  = kind;
      e.t     = t;
      e.mole  = mo;
      e.score = m_score;
      e.lives = m_lives;
      e.state = st;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int t);
      while (tcnt < t) @(negedge clk);
   endtask

   task automatic press(input logic [NM-1:0] mask);
      button = mask;
      @(negedge clk);
      button = '0;
   endtask

   // Arming decided at time t: mole and delay come from the LFSR at that cycle.
   task automatic arm(input int t);
      logic [15:0] x;
      x        = lfsr_at(t - t_rst);
      m_sel    = int'(x[15:14]);
      m_appear = t + MIND + int'(x[2:0]) + 2;
      push(KAppear, m_appear, 1 << m_sel, 2);
   endtask

   task automatic do_miss(input int td);
      if (m_lives == 1) begin
         m_lives = 0;
         m_end   = td + 1;
         push(KMiss, m_end, 15, 3);
         for (int j = 1; j <= 3; j++) push(KBlink, m_end + BLINK * j, (j % 2) ? 0 : 15, 3);
      end else begin
         m_lives--;
         push(KMiss, td + 1, 0, 1);
         arm(td);
      end
   endtask

   task automatic start_game();
      int t;
      repeat ($urandom_range(20, 1)) @(negedge clk);
      t       = tcnt;
      m_score = 0;
      m_lives = LIV0;
      arm(t);
      press(4'b0001);
   endtask

   task automatic do_hit(input int k);
      int t;
      logic [NM-1:0] mask;
      wait_until(m_appear + k);
      t    = tcnt;
      mask = NM'(1 << m_sel);
      if (m_score < 255) m_score++;
      push(KHit, t + 1, 0, 1);
      arm(t);
      press(mask);
   endtask

   task automatic do_timeout();
      int td;
      td = m_appear + WIN - 1;
      do_miss(td);
      wait_until(td + 1);
   endtask

   task automatic do_wrong(input int k);
      int t;
      logic [NM-1:0] mask;
      wait_until(m_appear + k);
      t    = tcnt;
      mask = NM'((1 << m_sel) | (1 << ((m_sel + 1) % NM)));
      do_miss(t);
      press(mask);
   endtask

   task automatic do_held();
      wait_until(m_appear - 2);
      button = NM'(1 << m_sel);
      do_timeout();
      button = '0;
   endtask

   task automatic end_exit();
      wait_until(m_end + 13);
      press(NM'($urandom_range(15, 1)));
      chk("exit_state", int'(state), 0);
      chk("exit_mole", int'(mole), 0);
      chk("exit_lives", int'(lives), 0);
      chk("exit_score", int'(score), m_score);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_mole"}, int'(mole), 0);
      chk({tag, "_score"}, int'(score), 0);
      chk({tag, "_lives"}, int'(lives), 0);
      chk({tag, "_hit"}, int'(hit), 0);
      chk({tag, "_miss"}, int'(miss), 0);
   endtask

   // Monitor: classifies what the DUT shows and compares it with the next expectation.
   logic [NM-1:0] prev_mole  = '0;
   logic [1:0]    prev_state = '0;
   exp_t          got;
   int            kind;

   always @(negedge clk) begin
      kind = -1;
      if (hit && miss) begin
         checks++;
         errors++;
         $display("FAIL hit_and_miss: both high at cycle %0d", tcnt);
      end
      if (hit) kind = KHit;
      else if (miss) kind = KMiss;
      else if (state == 2'd3 && prev_state == 2'd3 && mole != prev_mole) kind = KBlink;
      else if (state != 2'd3 && mole != '0 && mole != prev_mole) kind = KAppear;
      if (kind >= 0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, tcnt);
         end else begin
            got = sb.pop_front();
            chk("ev_kind", kind, got.kind);
            chk("ev_time", tcnt, got.t);
            chk("ev_mole", int'(mole), got.mole);
            chk("ev_score", int'(score), got.score);
            chk("ev_lives", int'(lives), got.lives);
            chk("ev_state", int'(state), got.state);
         end
      end
      prev_mole  = mole;
      prev_state = state;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion at cycle %0d", tcnt);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      t_rst = tcnt;

      // Game 1: hits incl. first and last visible cycle, wrong button, held button, timeout
      start_game();
      do_hit(5);
      do_hit(0);
      do_hit(WIN - 1);
      do_hit($urandom_range(WIN - 1, 0));
      do_wrong($urandom_range(WIN - 1, 0));
      do_held();
      do_timeout();
      end_exit();

      // Game 2: three timeouts to the end screen
      start_game();
      repeat (3) do_timeout();
      end_exit();

      // Game 3: score saturation, then reset while a mole is up
      start_game();
      repeat (258) do_hit($urandom_range(WIN - 1, 0));
      wait_until(m_appear + 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      t_rst = tcnt;
      sb.delete();
      m_score = 0;
      m_lives = 0;
      check_reset_outputs("midup_reset");

      // Game 4: LFSR sequence must restart from the seed
      start_game();
      do_hit($urandom_range(WIN - 1, 0));
      do_hit($urandom_range(WIN - 1, 0));
      wait_until(m_appear + 2);
      chk("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
